// File: rtl/uart_tx_buffer_if.sv
// Core-to-UART transmit bus: byte strobe from the core, line and FIFO status back.
`timescale 1ns/1ps
interface uart_tx_buffer_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                tx_ready;
  logic [7:0]          sdata;
  logic                txd;
  logic                busy;
  logic                full;
  logic                overflow;
  logic [DEPTH_LOG2:0] count;

  modport master (
    output tx_ready, sdata,
    input  txd, busy, full, overflow, count
  );

  modport slave (
    input  tx_ready, sdata,
    output txd, busy, full, overflow, count
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO fed by a one-cycle strobe, drained by an 8N1 UART serialiser.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (0) on the line
// DATA  | data bits, LSB first
// STOP  | stop bit (1); chains directly into START if more bytes are queued
`timescale 1ns/1ps
module uart_tx_buffer #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 4
) (
  input logic             clk,
  input logic             rst,
  uart_tx_buffer_if.slave bus
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CNT_W  = DEPTH_LOG2 + 1;
  localparam int BAUD_W = $clog2(CLK_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            mem [DEPTH];

  logic       full;
  logic       push;
  logic       pop;
  logic [7:0] head;

  // full comes from the pre-edge count, so a same-cycle pop cannot save a write
  assign full = (count_q == CNT_FULL);
  assign push = bus.tx_ready & ~full;
  assign head = mem[rptr_q];

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = BAUD_MAX;
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end

      S_START: begin
        txd_d = 1'b0;
        if (baud_q == '0) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
          baud_d    = BAUD_MAX;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_MAX;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

      S_STOP: begin
        txd_d = 1'b1;
        if (baud_q == '0) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = head;
            baud_d  = BAUD_MAX;
            state_d = S_START;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    wptr_d     = push ? wptr_q + DEPTH_LOG2'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + DEPTH_LOG2'(1) : rptr_q;
    overflow_d = overflow_q | (bus.tx_ready & full);
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wptr_q] <= bus.sdata;
    end
  end

  assign bus.txd      = txd_q;
  assign bus.busy     = (state_q != S_IDLE) | (count_q != '0);
  assign bus.full     = full;
  assign bus.overflow = overflow_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomised and directed bench for uart_tx_buffer against a frame-level line model.
`timescale 1ns/1ps
module tb_uart_tx_buffer;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_buffer_if #(.DEPTH_LOG2(DL2)) u_if ();

  uart_tx_buffer #(
    .CLK_PER_BIT(CPB),
    .DEPTH_LOG2 (DL2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: a byte queue plus "which frame is on the line and how far into it"
  logic [7:0] m_q[$];
  logic [7:0] m_done[$];
  bit         m_in_frame = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;
  int         m_pre = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_in_frame = 1'b0;
      m_pos      = 0;
      m_ovf      = 1'b0;
    end else begin
      m_pre = m_q.size();
      if (m_in_frame) begin
        m_pos++;
        if (m_pos == FRAME) begin
          m_done.push_back(m_cur);
          if (m_pre != 0) begin
            m_cur = m_q.pop_front();
            m_pos = 0;
          end else begin
            m_in_frame = 1'b0;
          end
        end
      end else if (m_pre != 0) begin
        m_cur      = m_q.pop_front();
        m_pos      = 0;
        m_in_frame = 1'b1;
      end
      if (u_if.tx_ready) begin
        if (m_pre == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(u_if.sdata);
      end
    end
  end

  function automatic logic frame_bit(logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic logic [6:0] exp_vec();
    logic t;
    int   sz;
    sz = m_q.size();
    t  = m_in_frame ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
    return {t, (m_in_frame || sz != 0), (sz == DEPTH), m_ovf, 3'(sz)};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {u_if.txd, u_if.busy, u_if.full, u_if.overflow, u_if.count};
  endfunction

  // Line decoder: samples txd mid-bit after each falling start edge
  logic [7:0] rx_q[$];
  bit         rx_act = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (u_if.txd === 1'b0) begin
        rx_act = 1'b1;
        rx_t   = 0;
      end
    end else begin
      rx_t++;
      if ((rx_t % CPB) == CPB / 2 && rx_t / CPB >= 1 && rx_t / CPB <= 8)
        rx_byte[rx_t/CPB-1] = u_if.txd;
      if (rx_t == 9 * CPB + CPB / 2) begin
        if (u_if.txd === 1'b1) rx_q.push_back(rx_byte);
        rx_act = 1'b0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    u_if.tx_ready = 1'b0;
    u_if.sdata = 8'h00;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== 7'b1000000) begin
        n_err++;
        $display("FAIL reset_hold got=%b want=%b", dut_vec(), 7'b1000000);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== 7'b1000000) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", c, dut_vec(), 7'b1000000);
      end
    end
  endtask

  task automatic test_single();
    m_done.delete();
    rx_q.delete();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL single cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec());
        end
      end
      if (c == 41 || c == 42) begin
        n_cmp++;
        if (u_if.busy !== (c == 41)) begin
          n_err++;
          $display("FAIL single_busy_edge cyc=%0d got=%b want=%b", c, u_if.busy, (c == 41));
        end
      end
      u_if.tx_ready = (c == 0);
      u_if.sdata    = 8'h55;
    end
    u_if.tx_ready = 1'b0;
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      n_err++;
      $display("FAIL single_decode got_n=%0d want byte 55", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] st[2];
    int max_cnt;
    st[0] = 8'h41;
    st[1] = 8'h42;
    max_cnt = 0;
    m_done.delete();
    rx_q.delete();
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
      if (int'(u_if.count) > max_cnt) max_cnt = int'(u_if.count);
      u_if.tx_ready = (c < 2);
      u_if.sdata    = (c < 2) ? st[c] : 8'h00;
    end
    u_if.tx_ready = 1'b0;
    n_cmp++;
    if (max_cnt != 1) begin
      n_err++;
      $display("FAIL b2b_peak_count got=%0d want=1", max_cnt);
    end
    n_cmp++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h41 || rx_q[1] !== 8'h42) begin
      n_err++;
      $display("FAIL b2b_decode got_n=%0d want 41,42", rx_q.size());
    end
  endtask

  task automatic test_overflow();
    m_done.delete();
    rx_q.delete();
    for (int c = 0; c < 5 * FRAME + 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL ovf cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
      if (c == 5) begin
        n_cmp++;
        if (u_if.full !== 1'b1) begin
          n_err++;
          $display("FAIL ovf_full_after_5th got=%b want=1", u_if.full);
        end
      end
      if (c >= 6) begin
        n_cmp++;
        if (u_if.overflow !== 1'b1) begin
          n_err++;
          $display("FAIL ovf_sticky cyc=%0d got=%b want=1", c, u_if.overflow);
        end
      end
      u_if.tx_ready = (c < 6);
      u_if.sdata    = 8'h10 + 8'(c);
    end
    u_if.tx_ready = 1'b0;
    n_cmp++;
    if (rx_q.size() != 5) begin
      n_err++;
      $display("FAIL ovf_decode_n got=%0d want=5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (rx_q[i] !== 8'h10 + 8'(i)) begin
          n_err++;
          $display("FAIL ovf_decode[%0d] got=%h want=%h", i, rx_q[i], 8'h10 + 8'(i));
        end
      end
    end
    n_cmp++;
    if (u_if.count !== 3'd0) begin
      n_err++;
      $display("FAIL ovf_drain_count got=%0d want=0", u_if.count);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] st[3];
    st[0] = 8'hA5;
    st[1] = 8'hB1;
    st[2] = 8'hB2;
    m_done.delete();
    rx_q.delete();
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 20) begin
        n_cmp++;
        if (dut_vec() !== 7'b1000000) begin
          n_err++;
          $display("FAIL midrst_after got=%b want=%b", dut_vec(), 7'b1000000);
        end
      end
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL midrst cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
      if (c == 19) begin
        n_cmp++;
        if (u_if.count !== 3'd2) begin
          n_err++;
          $display("FAIL midrst_queued got=%0d want=2", u_if.count);
        end
      end
      rst           = (c == 19);
      u_if.tx_ready = (c < 3);
      u_if.sdata    = (c < 3) ? st[c] : 8'h00;
    end
    u_if.tx_ready = 1'b0;
    n_cmp++;
    if (rx_q.size() != 0) begin
      n_err++;
      $display("FAIL midrst_decode got_n=%0d want=0", rx_q.size());
    end
  endtask

  task automatic test_extremes();
    logic want;
    m_done.delete();
    rx_q.delete();
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL ext cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
      if (c >= 2 && c <= 81) begin
        want = !((c <= 37) || (c >= 42 && c <= 45));
        n_cmp++;
        if (u_if.txd !== want) begin
          n_err++;
          $display("FAIL ext_wave cyc=%0d got=%b want=%b", c, u_if.txd, want);
        end
      end
      u_if.tx_ready = (c < 2);
      u_if.sdata    = (c == 0) ? 8'h00 : 8'hFF;
    end
    u_if.tx_ready = 1'b0;
    n_cmp++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
      n_err++;
      $display("FAIL ext_decode got_n=%0d want 00,FF", rx_q.size());
    end
  endtask

  task automatic test_random();
    m_done.delete();
    rx_q.delete();
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL rand cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
      u_if.tx_ready = (c < 600) && ($urandom_range(0, 29) == 0);
      u_if.sdata    = 8'($urandom);
    end
    u_if.tx_ready = 1'b0;
    repeat (4 * FRAME) @(negedge clk);
    n_cmp++;
    if (rx_q.size() != m_done.size()) begin
      n_err++;
      $display("FAIL rand_decode_n got=%0d want=%0d", rx_q.size(), m_done.size());
    end else begin
      for (int i = 0; i < rx_q.size(); i++) begin
        n_cmp++;
        if (rx_q[i] !== m_done[i]) begin
          n_err++;
          $display("FAIL rand_decode[%0d] got=%h want=%h", i, rx_q[i], m_done[i]);
        end
      end
    end
  endtask

  initial begin
    u_if.tx_ready = 1'b0;
    u_if.sdata    = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_extremes();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
